// File: rtl/vga_fb_scanout_if.sv
// vga_fb_scanout_if: pixel-plot bus carrying drawer writes into the framebuffer.
interface vga_fb_scanout_if;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   modport master (output vga_x, vga_y, vga_colour, vga_plot);
   modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 160x120x3 framebuffer fed by the plot bus, scanned out in raster
// order with sync, plus a bulk clear engine.
module vga_fb_scanout #(
   parameter int H_FP   = 4,
   parameter int H_SYNC = 12,
   parameter int H_BP   = 4,
   parameter int V_FP   = 2,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_fb_scanout_if.slave  plot,
   input  logic             clear,
   input  logic [2:0]       clear_colour,
   output logic             busy,
   output logic [7:0]       pix_x,
   output logic [6:0]       pix_y,
   output logic [2:0]       pix_colour,
   output logic             pix_valid,
   output logic             hsync_n,
   output logic             vsync_n,
   output logic             frame_start
);
   localparam int FB_SIZE = 160 * 120;
   localparam logic [8:0] H_ACT  = 9'd160;
   localparam logic [8:0] H_MAX  = 9'(160 + H_FP + H_SYNC + H_BP - 1);
   localparam logic [8:0] HS_ON  = 9'(160 + H_FP);
   localparam logic [8:0] HS_OFF = 9'(160 + H_FP + H_SYNC);
   localparam logic [7:0] V_ACT  = 8'd120;
   localparam logic [7:0] V_MAX  = 8'(120 + V_FP + V_SYNC + V_BP - 1);
   localparam logic [7:0] VS_ON  = 8'(120 + V_FP);
   localparam logic [7:0] VS_OFF = 8'(120 + V_FP + V_SYNC);
   localparam logic [14:0] CLR_LAST = 15'(FB_SIZE - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t      state;
   logic [14:0] clr_addr, wr_addr, rd_addr;
   logic [2:0]  clr_col, wr_data;
   logic [8:0]  h;
   logic [7:0]  v;
   logic        active, wr_en;
   logic [2:0]  fb [FB_SIZE];

   // y*160 + x without a multiplier
   function automatic logic [14:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
      return {1'b0, y, 7'd0} + {3'd0, y, 5'd0} + {7'd0, x};
   endfunction

   always_comb begin
      active  = h < H_ACT && v < V_ACT;
      wr_en   = busy || (plot.vga_plot && plot.vga_x < 8'd160 && plot.vga_y < 7'd120);
      wr_addr = busy ? clr_addr : fb_addr(plot.vga_y, plot.vga_x);
      wr_data = busy ? clr_col : plot.vga_colour;
      rd_addr = active ? fb_addr(v[6:0], h[7:0]) : 15'd0;
   end

   always_ff @(posedge clk)
      if (wr_en) fb[wr_addr] <= wr_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         clr_addr <= 15'd0;
         clr_col  <= 3'd0;
      end else if (state == IDLE) begin
         if (clear) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= 15'd0;
            clr_col  <= clear_colour;
         end
      end else begin
         clr_addr <= clr_addr + 15'd1;
         if (clr_addr == CLR_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end

   // read-before-write falls out of the registered read sampling the old array
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         h           <= 9'd0;
         v           <= 8'd0;
         pix_valid   <= 1'b0;
         pix_x       <= 8'd0;
         pix_y       <= 7'd0;
         pix_colour  <= 3'd0;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         h           <= h == H_MAX ? 9'd0 : h + 9'd1;
         if (h == H_MAX) v <= v == V_MAX ? 8'd0 : v + 8'd1;
         pix_valid   <= active;
         pix_x       <= h[7:0];
         pix_y       <= v[6:0];
         pix_colour  <= active ? fb[rd_addr] : 3'd0;
         hsync_n     <= !(h >= HS_ON && h < HS_OFF);
         vsync_n     <= !(v >= VS_ON && v < VS_OFF);
         frame_start <= h == 9'd0 && v == 8'd0;
      end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: randomized-colour scenarios checked against a position/array
// model of the display built from the raster arithmetic.
module tb_vga_fb_scanout;
   localparam logic [22:0] RST_VEC = 23'h00000C;

   logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
   logic [2:0] clear_colour = 3'd0;
   logic       busy, pix_valid, hsync_n, vsync_n, frame_start;
   logic [7:0] pix_x;
   logic [6:0] pix_y;
   logic [2:0] pix_colour;
   logic [22:0] obs, raw, exp_vec;

   vga_fb_scanout_if bus();

   vga_fb_scanout dut (
      .clk(clk), .rst_n(rst_n), .plot(bus), .clear(clear), .clear_colour(clear_colour),
      .busy(busy), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
      .pix_valid(pix_valid), .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   assign raw = {pix_valid, pix_x, pix_y, pix_colour, hsync_n, vsync_n, frame_start, busy};
   assign obs = {pix_valid, pix_valid ? pix_x : 8'd0, pix_valid ? pix_y : 7'd0,
                 pix_valid ? pix_colour : 3'd0, hsync_n, vsync_n, frame_start, busy};

   int total = 0, bad = 0;
   logic [2:0] fbm [19200];
   logic [2:0] frame_seen [19200];
   int mpos = 0, clr_i = 0;
   bit mbusy = 0;
   logic [2:0] clr_c = 3'd0;
   logic [2:0] c_a, c_b, c_c, c_d;

   // one clock of the display model: expected output for the current raster position,
   // then the memory effect of this cycle's inputs
   task automatic step();
      int h, v;
      bit act;
      h = mpos % 180;
      v = mpos / 180;
      act = h < 160 && v < 120;
      exp_vec = {act, act ? 8'(h) : 8'd0, act ? 7'(v) : 7'd0, act ? fbm[v*160+h] : 3'd0,
                 !(h >= 164 && h < 176), !(v >= 122 && v < 124), mpos == 0, 1'b0};
      if (mbusy) begin
         fbm[clr_i] = clr_c;
         clr_i++;
         if (clr_i == 19200) mbusy = 0;
      end else begin
         if (bus.vga_plot && bus.vga_x < 8'd160 && bus.vga_y < 7'd120)
            fbm[int'(bus.vga_y)*160 + int'(bus.vga_x)] = bus.vga_colour;
         if (clear) begin
            mbusy = 1;
            clr_i = 0;
            clr_c = clear_colour;
         end
      end
      exp_vec[0] = mbusy;
      mpos = (mpos + 1) % 23040;
      @(posedge clk);
      #1;
   endtask

   task automatic plot_px(input int x, input int y, input logic [2:0] c);
      bus.vga_x = 8'(x);
      bus.vga_y = 7'(y);
      bus.vga_colour = c;
      bus.vga_plot = 1'b1;
      step();
      bus.vga_plot = 1'b0;
   endtask

   task automatic test_reset();
      bus.vga_plot = 1'b0;
      bus.vga_x = 8'd0;
      bus.vga_y = 7'd0;
      bus.vga_colour = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (raw !== RST_VEC) begin bad++; $display("FAIL reset_values got=%h want=%h", raw, RST_VEC); end
      #4 rst_n = 1'b1;
      mpos = 0;
      mbusy = 0;
      step();
      total++;
      if ({pix_valid, frame_start, pix_x, pix_y, busy} !== {1'b1, 1'b1, 8'd0, 7'd0, 1'b0}) begin
         bad++;
         $display("FAIL first_pixel got v=%b fs=%b x=%0d y=%0d busy=%b want v=1 fs=1 x=0 y=0 busy=0",
                  pix_valid, frame_start, pix_x, pix_y, busy);
      end
   endtask

   task automatic test_clear_plot();
      int n = 0;
      clear = 1'b1;
      clear_colour = 3'd0;
      step();
      clear = 1'b0;
      while (busy === 1'b1 && n < 20000) begin step(); n++; end
      total++;
      if (n !== 19200) begin bad++; $display("FAIL clear_busy_len got=%0d want=19200", n); end
      plot_px(5, 7, c_a);
      plot_px(159, 119, c_b);
      plot_px(10, 10, c_c);
      plot_px(160, 0, 3'd7);
      plot_px(0, 120, 3'd7);
   endtask

   task automatic test_scan_frame();
      int n = 0, mis = 0, first_i = -1, nz = 0;
      int last_rise = 0, last_fall = -1, low_at = 0, falls = 0, vlow = 0, fs_cnt = 0, fs_at = -1;
      int wmin = 9999, wmax = -1, omin = 9999, omax = -1, pmin = 9999, pmax = -1;
      logic [22:0] first_obs = '0, first_exp = '0;
      logic ph, pv;
      while (frame_start !== 1'b1 && n < 24000) begin step(); n++; end
      total++;
      if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_start_wait got=%b want=1", frame_start); end
      frame_seen[0] = pix_colour;
      ph = hsync_n;
      pv = pix_valid;
      for (int i = 1; i <= 23040; i++) begin
         if (i == 1810) begin
            bus.vga_x = 8'd10;
            bus.vga_y = 7'd10;
            bus.vga_colour = c_d;
            bus.vga_plot = 1'b1;
         end
         step();
         bus.vga_plot = 1'b0;
         if (obs !== exp_vec) begin
            if (mis == 0) begin first_i = i; first_obs = obs; first_exp = exp_vec; end
            mis++;
         end
         if (i < 23040 && i % 180 < 160 && i / 180 < 120) frame_seen[(i/180)*160 + i%180] = pix_colour;
         if (pix_valid && !pv) last_rise = i;
         if (!hsync_n && ph) begin
            falls++;
            if (i - last_rise < 180) begin
               omin = (i - last_rise < omin) ? i - last_rise : omin;
               omax = (i - last_rise > omax) ? i - last_rise : omax;
            end
            if (last_fall >= 0) begin
               pmin = (i - last_fall < pmin) ? i - last_fall : pmin;
               pmax = (i - last_fall > pmax) ? i - last_fall : pmax;
            end
            last_fall = i;
            low_at = i;
         end
         if (hsync_n && !ph) begin
            wmin = (i - low_at < wmin) ? i - low_at : wmin;
            wmax = (i - low_at > wmax) ? i - low_at : wmax;
         end
         if (!vsync_n) vlow++;
         if (frame_start) begin fs_cnt++; fs_at = i; end
         ph = hsync_n;
         pv = pix_valid;
      end
      total++;
      if (mis != 0) begin
         bad++;
         $display("FAIL scan_model %0d cycles differ, first at %0d got=%h want=%h", mis, first_i, first_obs, first_exp);
      end
      total++; if (wmin != 12) begin bad++; $display("FAIL hsync_width_min got=%0d want=12", wmin); end
      total++; if (wmax != 12) begin bad++; $display("FAIL hsync_width_max got=%0d want=12", wmax); end
      total++; if (omin != 164) begin bad++; $display("FAIL hsync_offset_min got=%0d want=164", omin); end
      total++; if (omax != 164) begin bad++; $display("FAIL hsync_offset_max got=%0d want=164", omax); end
      total++; if (pmin != 180) begin bad++; $display("FAIL hsync_period_min got=%0d want=180", pmin); end
      total++; if (pmax != 180) begin bad++; $display("FAIL hsync_period_max got=%0d want=180", pmax); end
      total++; if (falls != 128) begin bad++; $display("FAIL hsync_count got=%0d want=128", falls); end
      total++; if (vlow != 360) begin bad++; $display("FAIL vsync_low_cycles got=%0d want=360", vlow); end
      total++; if (fs_cnt != 1) begin bad++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt); end
      total++; if (fs_at != 23040) begin bad++; $display("FAIL frame_period got=%0d want=23040", fs_at); end
      total++;
      if (frame_seen[1125] !== c_a) begin bad++; $display("FAIL pixel_5_7 got=%b want=%b", frame_seen[1125], c_a); end
      total++;
      if (frame_seen[19199] !== c_b) begin bad++; $display("FAIL pixel_159_119 got=%b want=%b", frame_seen[19199], c_b); end
      total++;
      if (frame_seen[160] !== 3'd0) begin bad++; $display("FAIL no_wrap_0_1 got=%b want=000", frame_seen[160]); end
      total++;
      if (frame_seen[1610] !== c_c) begin bad++; $display("FAIL collision_old got=%b want=%b", frame_seen[1610], c_c); end
      for (int a = 0; a < 19200; a++)
         if (a != 1125 && a != 19199 && a != 1610 && frame_seen[a] !== 3'd0) nz++;
      total++;
      if (nz != 0) begin bad++; $display("FAIL background got=%0d nonzero pixels want=0", nz); end
   endtask

   task automatic test_collision();
      while (mpos != 1810) step();
      step();
      total++;
      if ({pix_valid, pix_x, pix_y, pix_colour} !== {1'b1, 8'd10, 7'd10, c_d}) begin
         bad++;
         $display("FAIL collision_new got x=%0d y=%0d c=%b want x=10 y=10 c=%b", pix_x, pix_y, pix_colour, c_d);
      end
   endtask

   task automatic test_clear_twice();
      int n = 0, mis = 0, other = 0;
      clear = 1'b1;
      clear_colour = 3'b010;
      step();
      clear = 1'b0;
      while (busy === 1'b1 && n < 20000) begin
         clear = n == 99;
         clear_colour = n == 99 ? 3'b110 : 3'b000;
         if (n == 50) begin bus.vga_x = 8'd159; bus.vga_y = 7'd119; bus.vga_colour = 3'd7; bus.vga_plot = 1'b1; end
         if (n == 51) begin bus.vga_x = 8'd0; bus.vga_y = 7'd118; bus.vga_colour = 3'd5; bus.vga_plot = 1'b1; end
         step();
         clear = 1'b0;
         bus.vga_plot = 1'b0;
         n++;
      end
      total++;
      if (n !== 19200) begin bad++; $display("FAIL reclear_busy_len got=%0d want=19200", n); end
      while (mpos != 21600) begin
         step();
         if (obs !== exp_vec) mis++;
         if (pix_valid && pix_colour !== 3'b010) other++;
      end
      total++;
      if (mis != 0) begin bad++; $display("FAIL reclear_model got=%0d differing cycles want=0", mis); end
      total++;
      if (other != 0) begin bad++; $display("FAIL reclear_colour got=%0d non-010 pixels want=0", other); end
   endtask

   task automatic test_reset_mid_clear();
      int mis = 0;
      clear = 1'b1;
      clear_colour = 3'b101;
      step();
      clear = 1'b0;
      repeat (4999) step();
      rst_n = 1'b0;
      #1;
      total++;
      if (raw !== RST_VEC) begin bad++; $display("FAIL async_reset got=%h want=%h", raw, RST_VEC); end
      mpos = 0;
      mbusy = 0;
      @(posedge clk);
      #4 rst_n = 1'b1;
      step();
      total++;
      if ({pix_valid, frame_start, pix_x, pix_y, busy, pix_colour} !== {1'b1, 1'b1, 8'd0, 7'd0, 1'b0, 3'b101}) begin
         bad++;
         $display("FAIL post_reset_first got=%h want=%h", raw, {1'b1, 8'd0, 7'd0, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0});
      end
      while (mpos != 5800) begin
         step();
         if (obs !== exp_vec) mis++;
      end
      total++;
      if (mis != 0) begin bad++; $display("FAIL partial_clear got=%0d differing cycles want=0", mis); end
   endtask

   initial begin
      c_a = 3'($urandom_range(1, 7));
      c_b = 3'($urandom_range(1, 7));
      c_c = 3'($urandom_range(1, 7));
      c_d = c_c ^ 3'($urandom_range(1, 7));
      test_reset();
      test_clear_plot();
      test_scan_frame();
      test_collision();
      test_clear_twice();
      test_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vga_fb_scanout.md
# vga_fb_scanout

Receiving end of the pixel-plot interface driven by the fillscreen and Reuleaux-triangle drawers. It accepts `vga_x/vga_y/vga_colour/vga_plot` writes into an on-chip 160x120x3-bit framebuffer. It continuously reads the framebuffer back in raster order as a pixel stream with horizontal and vertical sync, so drawer output can be checked at the display side rather than only at the drawer's ports. It also provides a bulk clear engine for blanking the screen.

## Interface
- `H_FP`, 4, horizontal front-porch cycles after active pixels
- `H_SYNC`, 12, hsync pulse width in cycles
- `H_BP`, 4, horizontal back-porch cycles
- `V_FP`, 2, vertical front-porch lines
- `V_SYNC`, 2, vsync pulse width in lines
- `V_BP`, 4, vertical back-porch lines
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `vga_x`  in  8  write column
- `vga_y`  in  7  write row
- `vga_colour`  in  3  write colour
- `vga_plot`  in  1  write strobe, one pixel per cycle
- `clear`  in  1  start bulk clear (pulse)
- `clear_colour`  in  3  fill colour for clear, sampled with `clear`
- `busy`  out  1  clear in progress
- `pix_x`  out  8  scan-out column
- `pix_y`  out  7  scan-out row
- `pix_colour`  out  3  scan-out colour
- `pix_valid`  out  1  scan-out pixel is in the active area
- `hsync_n`  out  1  active-low horizontal sync
- `vsync_n`  out  1  active-low vertical sync
- `frame_start`  out  1  one-cycle pulse that accompanies pixel (0,0)

## Operation
- Framebuffer: 19200 x 3 bits. Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits. One write port and one read port.
- Write path:
  - A write occurs on any cycle with `vga_plot`=1, `busy`=0, x<160 and y<120.
  - Out-of-range writes are dropped silently. No wrap: x=160 does not alias to (0,y+1).
- Clear engine (states IDLE, CLEAR):
  - In IDLE, `clear`=1 latches `clear_colour`, sets the address counter to 0 and enters CLEAR.
  - In CLEAR, the engine writes one address per cycle with the latched colour, for addresses 0..19199. After writing 19199 it returns to IDLE.
  - `clear` is ignored while in CLEAR.
  - `vga_plot` writes are ignored while in CLEAR.
- Scan counters:
  - h runs 0..H_TOTAL-1 with H_TOTAL = 160+H_FP+H_SYNC+H_BP (180 at defaults).
  - v runs 0..V_TOTAL-1 with V_TOTAL = 120+V_FP+V_SYNC+V_BP (128 at defaults).
  - h increments every cycle. v increments when h wraps to 0. v wraps to 0 after V_TOTAL-1.
- Active area: h<160 and v<120. The read address is y*160+x for (h,v) and is only meaningful in the active area.
- Sync windows:
  - hsync is active for h in [160+H_FP, 160+H_FP+H_SYNC).
  - vsync is active for v in [120+V_FP, 120+V_FP+V_SYNC), for the whole line.
- Scanning never stalls. Clear and writes do not affect counter timing.
- Same-cycle write and read of one address: the read returns the old contents (read-before-write). The new value appears on the next frame.

## Timing
- Reset (rst_n=0), asynchronous:
  - h=0, v=0, state IDLE.
  - `busy`=0, `pix_valid`=0, `pix_colour`=0, `pix_x`=0, `pix_y`=0, `hsync_n`=1, `vsync_n`=1, `frame_start`=0.
  - Framebuffer contents are not reset.
- Read latency:
  - All scan outputs are registered one cycle after the (h,v) that produced them. This includes `pix_colour`, which comes from the synchronous memory read.
  - The first rising edge after rst_n deasserts presents (0,0): `pix_valid`=1 and `frame_start`=1.
- Write-to-visibility: a pixel written at cycle t is visible from the next read of its address strictly after t.
- `busy`:
  - Rises on the edge after `clear` is sampled in IDLE and stays high for exactly 19200 cycles.
  - A `vga_plot` write accepted on the cycle `busy` falls is not lost.
- `pix_valid`: high for 160 consecutive cycles per active line, then low for H_TOTAL-160 cycles.
- Reset mid-clear: `busy` drops immediately and the framebuffer is partially cleared. A new `clear` is needed.

## Test plan
- Clear with `clear_colour`=000 and wait 19200 cycles. Then plot (5,7) colour 101 and (159,119) colour 011. On the next frame, `pix_colour`=101 exactly when pix_x=5 and pix_y=7, 011 at (159,119), and 000 elsewhere.
- Plot at x=160,y=0 and at x=0,y=120 with colour 111 after a clear to 000. The next frame shows all 000; (0,1) is unchanged.
- Pulse `clear` with colour 010, then pulse it again 100 cycles later with 110. `busy` is high for exactly 19200 cycles and the frame is all 010. A `vga_plot` issued while busy has no effect.
- At defaults, measure sync:
  - The hsync_n low pulse lasts 12 cycles.
  - hsync_n falls 164 cycles after the first `pix_valid` of a line, with a 180-cycle period.
  - vsync_n is low for 2 lines and the frame period is 23040 cycles.
  - `frame_start` pulses once per frame.
- Write (10,10) with colour 100 on the same cycle the scan reads (10,10), which held 001. This frame shows 001; the next frame shows 100.
- Assert rst_n mid-clear at cycle 5000. All outputs go to their reset values asynchronously. `busy`=0 after release. The first output after release is (0,0) with `frame_start`=1.
